vec_resp_checker: RTL and testbench

- Synthesizable response checker for the test-vector flow: it is the consuming end of the vector stream that the bench produces.
- Golden output vectors are preloaded into an internal memory. DUT responses are then streamed in, in order, and each is compared against its golden entry.
- Reports pass/fail, a saturating mismatch count and the index of the first failing vector.
- Sits beside the UUT in hardware-in-loop and emulation runs, replacing file-based output comparison.

---
 rtl/vec_check_pkg.sv | 21 ++
 rtl/vec_golden_mem.sv | 40 ++++
 rtl/vec_resp_checker.sv | 153 +++++++++++++++
 tb/tb_vec_resp_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_check_pkg.sv
// Shared types and compare function for the vector response checker.
// The function serves both the plain compare and the masked compare (VEC_RESP_CHECKER_MASK_EN).
package vec_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest response vector the compare function accepts; callers zero-extend.
    localparam int MAX_W = 64;

    // Mask bits set to 1 are don't-care; pass an all-zero mask for full-width equality.
    function automatic logic vec_mismatch(input logic [MAX_W-1:0] resp,
                                          input logic [MAX_W-1:0] gold,
                                          input logic [MAX_W-1:0] mask);
        return |((resp ^ gold) & ~mask);
    endfunction

endpackage

// File: rtl/vec_golden_mem.sv
// Golden vector store: one write port and an asynchronous read port.
// With VEC_RESP_CHECKER_MASK_EN defined, it also holds a parallel don't-care mask.
module vec_golden_mem #(
    parameter int W     = 1,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
`ifdef VEC_RESP_CHECKER_MASK_EN
    input  logic [W-1:0]  wmask,
    output logic [W-1:0]  rmask,
`endif
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] data_r [DEPTH];
`ifdef VEC_RESP_CHECKER_MASK_EN
    logic [W-1:0] mask_r [DEPTH];
`endif

    // Write port: contents are never reset, so goldens survive a run abort.
    always_ff @(posedge clk) begin
        if (we) begin
            data_r[waddr] <= wdata;
`ifdef VEC_RESP_CHECKER_MASK_EN
            mask_r[waddr] <= wmask;
`endif
        end
    end

    assign rdata = data_r[raddr];
`ifdef VEC_RESP_CHECKER_MASK_EN
    assign rmask = mask_r[raddr];
`endif

endmodule

// File: rtl/vec_resp_checker.sv
// Compares a stream of DUT responses against preloaded golden vectors.
// Optional don't-care masking is enabled by defining VEC_RESP_CHECKER_MASK_EN.
module vec_resp_checker
    import vec_check_pkg::*;
#(
    parameter int OUTPUT_WIDTH    = 1,
    parameter int NUMBER_OF_TESTS = 8,
    parameter int IDX_W           = $clog2(NUMBER_OF_TESTS),
    parameter int CNT_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_we,
    input  logic [IDX_W-1:0]        load_idx,
    input  logic [OUTPUT_WIDTH-1:0] load_data,
`ifdef VEC_RESP_CHECKER_MASK_EN
    input  logic [OUTPUT_WIDTH-1:0] load_mask,
`endif
    input  logic                    start,
    input  logic                    resp_valid,
    output logic                    resp_ready,
    input  logic [OUTPUT_WIDTH-1:0] resp_data,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        mismatch_count,
    output logic                    first_fail_valid,
    output logic [IDX_W-1:0]        first_fail_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_TESTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_next_s;
    logic                    ready_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    pass_r;
    logic                    ffv_r;
    logic [IDX_W-1:0]        ffi_r;
    logic                    mem_we_s;
    logic                    accept_s;
    logic                    mism_s;
    logic [OUTPUT_WIDTH-1:0] gold_s;
    logic [OUTPUT_WIDTH-1:0] mask_s;

    // Goldens are frozen while a run is in progress.
    assign mem_we_s = load_we && (state_r != RUN);
    assign accept_s = resp_valid && ready_r;

    vec_golden_mem #(
        .W     (OUTPUT_WIDTH),
        .DEPTH (NUMBER_OF_TESTS),
        .AW    (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (load_idx),
        .wdata (load_data),
`ifdef VEC_RESP_CHECKER_MASK_EN
        .wmask (load_mask),
        .rmask (mask_s),
`endif
        .raddr (idx_r),
        .rdata (gold_s)
    );

`ifndef VEC_RESP_CHECKER_MASK_EN
    assign mask_s = {OUTPUT_WIDTH{1'b0}};
`endif

    assign mism_s = vec_mismatch(MAX_W'(resp_data), MAX_W'(gold_s), MAX_W'(mask_s));

    // Saturating next value of the mismatch counter for the current cycle.
    always_comb begin
        cnt_next_s = cnt_r;
        if (accept_s && mism_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Run-control FSM and all registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            ffv_r   <= 1'b0;
            ffi_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r <= RUN;
                        idx_r   <= {IDX_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                        ffv_r   <= 1'b0;
                        ffi_r   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        cnt_r <= cnt_next_s;
                        if (mism_s && !ffv_r) begin
                            ffv_r <= 1'b1;
                            ffi_r <= idx_r;
                        end
                        if (idx_r == LAST_IDX) begin
                            state_r <= DONE;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (cnt_next_s == {CNT_W{1'b0}});
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign resp_ready       = ready_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign mismatch_count   = cnt_r;
    assign first_fail_valid = ffv_r;
    assign first_fail_idx   = ffi_r;

endmodule

// File: tb/tb_vec_resp_checker.sv
// Directed self-checking bench for vec_resp_checker; the masked-compare
// instance is only built when VEC_RESP_CHECKER_MASK_EN is defined.
module tb_vec_resp_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_we = 1'b0;
    logic [2:0] load_idx = 3'd0;
    logic [0:0] load_data = 1'b0;
    logic       start = 1'b0;
    logic       resp_valid = 1'b0;
    logic [0:0] resp_data = 1'b0;

    logic       ready, busy, done, pass, ffv;
    logic [7:0] cnt;
    logic [2:0] ffi;
    logic       s_ready, s_busy, s_done, s_pass, s_ffv;
    logic [1:0] s_cnt;
    logic [2:0] s_ffi;

    logic [7:0] gold = 8'b1001_0110;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec_resp_checker #(.OUTPUT_WIDTH(1), .NUMBER_OF_TESTS(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_idx(load_idx), .load_data(load_data),
`ifdef VEC_RESP_CHECKER_MASK_EN
        .load_mask(1'b0),
`endif
        .start(start), .resp_valid(resp_valid), .resp_ready(ready), .resp_data(resp_data),
        .busy(busy), .done(done), .pass(pass), .mismatch_count(cnt),
        .first_fail_valid(ffv), .first_fail_idx(ffi)
    );

    vec_resp_checker #(.OUTPUT_WIDTH(1), .NUMBER_OF_TESTS(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .load_we(load_we), .load_idx(load_idx), .load_data(load_data),
`ifdef VEC_RESP_CHECKER_MASK_EN
        .load_mask(1'b0),
`endif
        .start(start), .resp_valid(resp_valid), .resp_ready(s_ready), .resp_data(resp_data),
        .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch_count(s_cnt),
        .first_fail_valid(s_ffv), .first_fail_idx(s_ffi)
    );

`ifdef VEC_RESP_CHECKER_MASK_EN
    logic       m_we = 1'b0, m_start = 1'b0, m_valid = 1'b0;
    logic [2:0] m_idx = 3'd0;
    logic [3:0] m_data = 4'd0, m_mask = 4'd0, m_rdata = 4'd0;
    logic       m_ready, m_busy, m_done, m_pass, m_ffv;
    logic [7:0] m_cnt;
    logic [2:0] m_ffi;

    vec_resp_checker #(.OUTPUT_WIDTH(4), .NUMBER_OF_TESTS(8), .CNT_W(8)) dut_m (
        .clk(clk), .rst(rst), .load_we(m_we), .load_idx(m_idx), .load_data(m_data),
        .load_mask(m_mask), .start(m_start), .resp_valid(m_valid), .resp_ready(m_ready),
        .resp_data(m_rdata), .busy(m_busy), .done(m_done), .pass(m_pass),
        .mismatch_count(m_cnt), .first_fail_valid(m_ffv), .first_fail_idx(m_ffi)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_all(input logic [7:0] g);
        for (int i = 0; i < 8; i++) begin
            load_we = 1'b1; load_idx = i[2:0]; load_data = g[i];
            @(negedge clk);
        end
        load_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_ready", ready, 1);
        chk("run_done_cleared", done, 0);
    endtask

    // Streams 8 responses; gap idle cycles follow each non-final accept, during
    // which golden writes (to the not-yet-read next index) and a start may be issued.
    task automatic stream(input logic [7:0] resp, input int gap, input bit poke, input bit mid_start);
        int exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            resp_valid = 1'b1; resp_data = resp[i];
            if (i == 7) chk("done_before_last", done, 0);
            @(negedge clk);
            resp_valid = 1'b0;
            if (resp[i] !== gold[i]) exp_cnt++;
            chk("count_running", cnt, exp_cnt);
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    if (poke) begin
                        load_we = 1'b1; load_idx = 3'(i + 1); load_data = ~gold[i + 1];
                    end
                    if (mid_start && g == 0) start = 1'b1;
                    @(negedge clk);
                    load_we = 1'b0; start = 1'b0;
                end
            end
        end
        chk("done_after_last", done, 1);
        chk("busy_after_last", busy, 0);
        chk("ready_after_last", ready, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ffv", ffv, 0);
        chk("rst_ffi", ffi, 0);
        @(negedge clk);
        rst = 1'b0;

        // All responses correct
        load_all(gold);
        pulse_start();
        stream(gold, 0, 1'b0, 1'b0);
        chk("allpass_pass", pass, 1);
        chk("allpass_cnt", cnt, 0);
        chk("allpass_ffv", ffv, 0);
        resp_valid = 1'b1; resp_data = ~gold[0];
        @(negedge clk);
        resp_valid = 1'b0;
        chk("done_ignores_resp_cnt", cnt, 0);
        chk("done_held", done, 1);

        // Mismatches at index 2 and 5
        pulse_start();
        stream(gold ^ 8'b0010_0100, 0, 1'b0, 1'b0);
        chk("two_cnt", cnt, 2);
        chk("two_ffi", ffi, 2);
        chk("two_ffv", ffv, 1);
        chk("two_pass", pass, 0);

        // Gaps of two idle cycles, writes and a start issued mid-run
        pulse_start();
        stream(gold, 2, 1'b1, 1'b1);
        chk("gaps_pass", pass, 1);
        chk("gaps_cnt", cnt, 0);

        // Everything wrong: 2-bit counter saturates at 3
        pulse_start();
        stream(~gold, 0, 1'b0, 1'b0);
        chk("sat_cnt", s_cnt, 3);
        chk("sat_pass", s_pass, 0);
        chk("sat_ffi", s_ffi, 0);
        chk("sat_ffv", s_ffv, 1);
        chk("wide_cnt", cnt, 8);

        // Asynchronous reset after four accepts (one mismatch at index 1)
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1; resp_data = gold[i] ^ (i == 1);
            @(negedge clk);
        end
        resp_valid = 1'b0;
        chk("pre_rst_cnt", cnt, 1);
        chk("pre_rst_ffi", ffi, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_ffv", ffv, 0);
        chk("midrst_ffi", ffi, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sat_cnt", s_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        stream(gold, 0, 1'b0, 1'b0);
        chk("rerun_pass", pass, 1);

        // Golden write in the same cycle as start is used by that run
        load_we = 1'b1; load_idx = 3'd0; load_data = 1'b1; start = 1'b1;
        @(negedge clk);
        load_we = 1'b0; start = 1'b0;
        gold[0] = 1'b1;
        stream(gold, 0, 1'b0, 1'b0);
        chk("wr_start_pass", pass, 1);
        chk("wr_start_cnt", cnt, 0);

`ifdef VEC_RESP_CHECKER_MASK_EN
        // Masked compare: low two bits are don't-care; index 3 differs in bit 3
        for (int i = 0; i < 8; i++) begin
            m_we = 1'b1; m_idx = i[2:0]; m_data = 4'b1010; m_mask = 4'b0011;
            @(negedge clk);
        end
        m_we = 1'b0;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_valid = 1'b1; m_rdata = (i == 3) ? 4'b0010 : 4'b1001;
            @(negedge clk);
            if (i == 0) chk("mask_first_cnt", m_cnt, 0);
        end
        m_valid = 1'b0;
        chk("mask_cnt", m_cnt, 1);
        chk("mask_ffi", m_ffi, 3);
        chk("mask_done", m_done, 1);
        chk("mask_pass", m_pass, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
